// File: rtl/sound_pkg.sv
// sound_pkg: constants and types shared by the sound player and the sound recorder.
//   SAMPLE_DIV  - clk cycles per audio sample
//   PWM_PERIOD  - clk cycles per PWM frame (duty full-scale)
//   FIRST_ADDR  - first sample RAM address of a take
//   NUM_SAMPLES - samples per take
//   PWM_FULL    - duty value that drives the PWM output constantly high
package sound_pkg;

    localparam int          SAMPLE_DIV  = 512;
    localparam int          PWM_PERIOD  = 128;
    localparam logic [15:0] FIRST_ADDR  = 16'h0001;
    localparam int          NUM_SAMPLES = 65536;
    localparam logic [7:0]  PWM_FULL    = 8'd128;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} play_state_t;

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM frame counter with registered duty compare.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   en      in  1 while the output may toggle; 0 clears counter and output
//   restart in  restart the frame (counter back to 0) on the next edge
//   duty    in  high cycles per frame, 0..PWM_PERIOD
//   pwm_out out registered (pwm_cnt < duty)
module pwm_gen
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    input  logic [7:0] duty,
    output logic       pwm_out
);

    localparam int CNT_W = $clog2(PWM_PERIOD);

    logic [CNT_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            // The extra zero bit lets duty == PWM_PERIOD compare true for every count.
            pwm_out <= ({1'b0, pwm_cnt} < duty);
            if (restart) begin
                pwm_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_player.sv
// sound_player: reads one recorded take back from the sample RAM and plays it as PWM audio.
// Each sample is held for SAMPLE_DIV clk cycles; its PDM one-count (bits [9:2]) becomes the
// PWM duty, saturated to PWM_FULL.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   sw_play   in   play button (level); playback starts on its rising edge
//   data_addr out  RAM read address
//   data_din  in   RAM read data, valid RD_LAT cycles after data_addr
//   AUD_PWM   out  PWM audio
//   AUD_SD    out  amplifier enable, 1 while playing
//   play_busy out  1 while playing
// Build option: define PLAYER_LOOP_EN to repeat the take for as long as sw_play is held;
// without it every press plays the take exactly once.
module sound_player
    import sound_pkg::*;
#(
    parameter int          SAMPLE_DIV  = sound_pkg::SAMPLE_DIV,
    parameter int          RD_LAT      = 1,
    parameter logic [15:0] FIRST_ADDR  = sound_pkg::FIRST_ADDR,
    parameter int          NUM_SAMPLES = sound_pkg::NUM_SAMPLES
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_play,
    output logic [15:0] data_addr,
    input  logic [15:0] data_din,
    output logic        AUD_PWM,
    output logic        AUD_SD,
    output logic        play_busy
);

    localparam int                 TIMER_W    = $clog2(SAMPLE_DIV);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RD_LAT);
    localparam logic [16:0]        SMP_LAST   = 17'(NUM_SAMPLES - 1);

    play_state_t        state;
    logic               sw_play_d;
    logic [TIMER_W-1:0] timer;
    logic [16:0]        smp_cnt;
    logic [7:0]         duty;

    logic sample_end;
    logic take_end;
    logic loop_take;
    logic leave_play;
    logic duty_load;
    logic pwm_en;
    logic unused_lsbs;

    // Low two bits are below the one-count resolution.
    assign unused_lsbs = ^data_din[1:0];

    // smp holds data_din[15:2]: [13:8] are above the valid 0..512 range.
    function automatic logic [7:0] sat(input logic [13:0] smp);
        if ((smp[13:8] != '0) || (smp[7:0] > PWM_FULL)) begin
            return PWM_FULL;
        end
        return smp[7:0];
    endfunction

    assign sample_end = (state == PLAY) && (timer == TIMER_LAST);
    assign take_end   = sample_end && (smp_cnt == SMP_LAST);
    assign duty_load  = (state == PLAY) && (timer == TIMER_LOAD);

`ifdef PLAYER_LOOP_EN
    assign loop_take = sw_play;
`else
    assign loop_take = 1'b0;
`endif

    assign leave_play = take_end && !loop_take;

    // Dropping enable on the leaving edge makes AUD_PWM low in the first DONE cycle.
    assign pwm_en = (state == PLAY) && !leave_play;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sw_play_d <= 1'b0;
            timer     <= '0;
            smp_cnt   <= '0;
            data_addr <= '0;
            duty      <= '0;
            AUD_SD    <= 1'b0;
            play_busy <= 1'b0;
        end else begin
            sw_play_d <= sw_play;
            case (state)
                IDLE: begin
                    if (sw_play && !sw_play_d) begin
                        data_addr <= FIRST_ADDR;
                        timer     <= '0;
                        smp_cnt   <= '0;
                        // Zero duty keeps AUD_PWM low until the first sample arrives.
                        duty      <= '0;
                        state     <= PLAY;
                        AUD_SD    <= 1'b1;
                        play_busy <= 1'b1;
                    end
                end
                PLAY: begin
                    timer <= sample_end ? '0 : timer + 1'b1;
                    if (duty_load) begin
                        duty <= sat(data_din[15:2]);
                    end
                    if (sample_end) begin
                        if (leave_play) begin
                            state     <= DONE;
                            AUD_SD    <= 1'b0;
                            play_busy <= 1'b0;
                        end else if (take_end) begin
                            data_addr <= FIRST_ADDR;
                            smp_cnt   <= '0;
                        end else begin
                            data_addr <= data_addr + 16'd1;
                            smp_cnt   <= smp_cnt + 17'd1;
                        end
                    end
                end
                DONE: begin
                    if (!sw_play) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pwm_gen u_pwm (
        .clk     (clk),
        .rst     (rst),
        .en      (pwm_en),
        .restart (duty_load),
        .duty    (duty),
        .pwm_out (AUD_PWM)
    );

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: three instances share clk, rst and sw_play.
//   u_a : default parameters, RAM returns a[6:0]<<2 or a constant
//   u_b : NUM_SAMPLES=4, RAM returns a[6:0]<<2
//   u_c : FIRST_ADDR=FFFE, NUM_SAMPLES=4, RD_LAT=3, RAM returns 16'h0200
module tb_sound_player;

    logic clk;
    logic rst;
    logic sw_play;

    logic [15:0] addr_a, din_a, addr_b, din_b, addr_c, din_c;
    logic        pwm_a, sd_a, busy_a;
    logic        pwm_b, sd_b, busy_b;
    logic        pwm_c, sd_c, busy_c;
    logic [15:0] c_d1, c_d2;

    logic        use_const;
    logic [15:0] const_val;

    int nvec;
    int nerr;
    int t;

    typedef struct {
        logic [15:0] mem;
        int          highs;
    } vec_t;

    vec_t vecs[9];

    sound_player u_a (
        .clk(clk), .rst(rst), .sw_play(sw_play),
        .data_addr(addr_a), .data_din(din_a),
        .AUD_PWM(pwm_a), .AUD_SD(sd_a), .play_busy(busy_a)
    );

    sound_player #(.NUM_SAMPLES(4)) u_b (
        .clk(clk), .rst(rst), .sw_play(sw_play),
        .data_addr(addr_b), .data_din(din_b),
        .AUD_PWM(pwm_b), .AUD_SD(sd_b), .play_busy(busy_b)
    );

    sound_player #(.FIRST_ADDR(16'hFFFE), .NUM_SAMPLES(4), .RD_LAT(3)) u_c (
        .clk(clk), .rst(rst), .sw_play(sw_play),
        .data_addr(addr_c), .data_din(din_c),
        .AUD_PWM(pwm_c), .AUD_SD(sd_c), .play_busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models
    always @(posedge clk) begin
        din_a <= use_const ? const_val : {7'd0, addr_a[6:0], 2'b00};
        din_b <= {7'd0, addr_b[6:0], 2'b00};
        c_d1  <= (addr_c == 16'hFFFF) ? 16'h0200 : 16'h0200;
        c_d2  <= c_d1;
        din_c <= c_d2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the negedge following posedge E+k (E = the press edge).
    task automatic adv(input int k);
        if (k > t) begin
            repeat (k - t) @(posedge clk);
            @(negedge clk);
            t = k;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        sw_play = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with sw_play low; returns at the negedge after E.
    task automatic press();
        sw_play = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t = 0;
    endtask

    task automatic count_highs(input int from, output int n);
        n = 0;
        adv(from);
        for (int j = 0; j < 128; j++) begin
            if (pwm_a) n++;
            adv(from + j + 1);
        end
    endtask

    initial begin
        int n;
        int drops;
        logic [15:0] wrap_addr[4];

        nvec = 0;
        nerr = 0;
        t = 0;
        rst = 1'b1;
        sw_play = 1'b0;
        use_const = 1'b0;
        const_val = 16'h0000;

        vecs[0] = '{16'h0004, 1};
        vecs[1] = '{16'h0100, 64};
        vecs[2] = '{16'h01FC, 127};
        vecs[3] = '{16'h0200, 128};
        vecs[4] = '{16'hFFFF, 128};
        vecs[5] = '{16'h0204, 128};
        vecs[6] = '{16'h0400, 128};
        vecs[7] = '{16'h0000, 0};
        vecs[8] = '{16'h0003, 0};

        wrap_addr[0] = 16'hFFFE;
        wrap_addr[1] = 16'hFFFF;
        wrap_addr[2] = 16'h0000;
        wrap_addr[3] = 16'h0001;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", addr_a, 0);
        check("rst_pwm", pwm_a, 0);
        check("rst_sd", sd_a, 0);
        check("rst_busy", busy_a, 0);

        // rst and sw_play rising together: rst wins
        sw_play = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_wins_busy", busy_a, 0);
        check("rst_wins_addr", addr_a, 0);
        do_reset();

        // T1: address-pattern RAM
        press();
        check("t1_addr_first", addr_a, 1);
        check("t1_sd", sd_a, 1);
        check("t1_busy", busy_a, 1);
        count_highs(10, n);
        check("t1_smp1_highs", n, 1);
        adv(511);
        check("t1_addr_hold", addr_a, 1);
        adv(512);
        check("t1_addr_next", addr_a, 2);
        count_highs(522, n);
        check("t1_smp2_highs", n, 2);
        // Re-press while playing is ignored
        sw_play = 1'b0;
        adv(700);
        sw_play = 1'b1;
        adv(703);
        check("t1_ignore_addr", addr_a, 2);
        check("t1_ignore_busy", busy_a, 1);

        // T5: reset at timer 200 of sample 3
        adv(1224);
        check("t5_addr_before", addr_a, 3);
        rst = 1'b1;
        sw_play = 1'b0;
        adv(1225);
        check("t5_addr", addr_a, 0);
        check("t5_pwm", pwm_a, 0);
        check("t5_sd", sd_a, 0);
        check("t5_busy", busy_a, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_idle", busy_a, 0);
        press();
        check("t5_restart_addr", addr_a, 1);
        check("t5_restart_sd", sd_a, 1);

        // T2: duty / saturation table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            use_const = 1'b1;
            const_val = vecs[i].mem;
            press();
            adv(1);
            check($sformatf("vec%0d_forced_low", i), pwm_a, 0);
            count_highs(10, n);
            check($sformatf("vec%0d_highs", i), n, vecs[i].highs);
        end
        use_const = 1'b0;

        // T3 / T4: short take on u_b, sw_play held
        do_reset();
        press();
        adv(1);
        check("b_forced_low", pwm_b, 0);
        for (int k = 0; k < 4; k++) begin
            adv(512 * k + 5);
            check($sformatf("b_addr%0d", k), addr_b, 1 + k);
        end
        adv(2047);
        check("b_sd_last", sd_b, 1);
`ifdef PLAYER_LOOP_EN
        drops = 0;
        for (int c = 2048; c <= 2060; c++) begin
            adv(c);
            if (!sd_b) drops++;
        end
        check("t4_no_gap", drops, 0);
        check("t4_loop_addr", addr_b, 1);
        adv(2565);
        check("t4_loop_addr2", addr_b, 2);
        sw_play = 1'b0;
        adv(4095);
        check("t4_sd_before_end", sd_b, 1);
        adv(4096);
        check("t4_sd_done", sd_b, 0);
        check("t4_busy_done", busy_b, 0);
`else
        adv(2048);
        check("t3_sd_done", sd_b, 0);
        check("t3_busy_done", busy_b, 0);
        sw_play = 1'b0;
        adv(2050);
        check("t3_idle", busy_b, 0);
        sw_play = 1'b1;
        adv(2051);
        check("t3_restart_addr", addr_b, 1);
        check("t3_restart_sd", sd_b, 1);
        drops = 0;
`endif

        // T6: wrapping addresses and RD_LAT=3 on u_c
        do_reset();
        press();
        check("t6_sd", sd_c, 1);
        check("t6_busy", busy_c, 1);
        adv(4);
        check("t6_pwm_before_load", pwm_c, 0);
        adv(5);
        check("t6_pwm_after_load", pwm_c, 1);
        for (int k = 0; k < 4; k++) begin
            adv(512 * k + 6);
            check($sformatf("t6_addr%0d", k), addr_c, wrap_addr[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
